// File: rtl/eth_frame_scheduler.sv
// Round-robin frame scheduler: drains four FWFT FIFOs into a byte-wide transmitter
// as frames of a 2-byte header, PAYLOAD_LEN payload bytes, then an inter-frame gap.
module eth_frame_scheduler #(
   parameter int PAYLOAD_LEN = 1024,
   parameter int IFG_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ch_enable,
   input  logic [3:0]  ch_ready,
   input  logic [3:0]  ch_empty,
   input  logic [31:0] ch_dout,
   output logic [3:0]  ch_rd_en,
   input  logic        din_rdy,
   output logic        eth_en,
   output logic [7:0]  eth_data,
   output logic [1:0]  grant,
   output logic        frame_done,
   output logic        underrun,
   input  logic        clr_status
);

   localparam int             BCW       = $clog2(PAYLOAD_LEN + 1);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(PAYLOAD_LEN - 1);
   localparam logic [7:0]     LAST_GAP  = 8'(IFG_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, GAP} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [1:0]     r_grant;
   logic [1:0]     r_last_grant;
   logic [1:0]     w_pick;
   logic           w_pick_valid;
   logic [7:0]     r_seq [4];
   logic [BCW-1:0] r_byte_cnt;
   logic [7:0]     r_gap_cnt;
   logic           r_eth_en;
   logic           r_frame_done;
   logic           r_underrun;
   logic [3:0]     w_req;
   logic           w_xfer;
   logic           w_last_xfer;
   logic           w_gap_end;
   logic           w_granted_empty;
   logic [7:0]     w_granted_dout;

   assign w_req           = ch_ready & ch_enable;
   assign w_xfer          = r_eth_en & din_rdy;
   assign w_granted_empty = ch_empty[r_grant];
   assign w_granted_dout  = ch_dout[{r_grant, 3'b000} +: 8];
   assign w_last_xfer     = (r_state == PAYLOAD) && w_xfer && (r_byte_cnt == LAST_BYTE);
   assign w_gap_end       = (r_state == GAP) && (r_gap_cnt == LAST_GAP);

   // Scanning offsets 4 down to 1 lets the nearest requester after last_grant win.
   always_comb begin
      w_pick       = r_last_grant;
      w_pick_valid = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         if (w_req[r_last_grant + 2'(i)]) begin
            w_pick       = r_last_grant + 2'(i);
            w_pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_next = HDR0;
         HDR0:    if (w_xfer)       w_next = HDR1;
         HDR1:    if (w_xfer)       w_next = PAYLOAD;
         PAYLOAD: if (w_last_xfer)  w_next = GAP;
         GAP:     if (w_gap_end)    w_next = IDLE;
         default:                   w_next = IDLE;
      endcase
   end

   // Pops are suppressed during reset so an aborted frame cannot steal a FIFO byte.
   always_comb begin
      eth_data = 8'h00;
      ch_rd_en = 4'b0000;
      case (r_state)
         HDR0:    eth_data = {4'hA, 2'b00, r_grant};
         HDR1:    eth_data = r_seq[r_grant];
         PAYLOAD: begin
            eth_data          = w_granted_empty ? 8'h00 : w_granted_dout;
            ch_rd_en[r_grant] = din_rdy & ~w_granted_empty & ~rst;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant      <= 2'd0;
         r_last_grant <= 2'd3;
         r_byte_cnt   <= '0;
         r_gap_cnt    <= 8'd0;
         r_eth_en     <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_seq[i] <= 8'd0;
         end
      end else begin
         r_eth_en     <= (w_next inside {HDR0, HDR1, PAYLOAD});
         r_frame_done <= w_last_xfer;
         if (r_state == IDLE && w_pick_valid) begin
            r_grant <= w_pick;
         end
         if (r_state == PAYLOAD && w_xfer) begin
            r_byte_cnt <= w_last_xfer ? '0 : r_byte_cnt + BCW'(1);
         end
         if (r_state == GAP && !w_gap_end) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
         end else begin
            r_gap_cnt <= 8'd0;
         end
         if (w_last_xfer) begin
            r_seq[r_grant] <= r_seq[r_grant] + 8'd1;
            r_last_grant   <= r_grant;
         end
         // A fresh underrun takes priority over a simultaneous clear.
         if (r_state == PAYLOAD && din_rdy && w_granted_empty) begin
            r_underrun <= 1'b1;
         end else if (clr_status) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign eth_en     = r_eth_en;
   assign grant      = r_grant;
   assign frame_done = r_frame_done;
   assign underrun   = r_underrun;

endmodule

// File: tb/tb_eth_frame_scheduler.sv
// Bench for eth_frame_scheduler: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed byte sequences.
module tb_eth_frame_scheduler;

   localparam int PL  = 4;
   localparam int IFG = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ch_enable;
   logic [3:0]  ch_ready;
   logic [3:0]  ch_empty;
   logic [31:0] ch_dout;
   logic [3:0]  ch_rd_en;
   logic        din_rdy;
   logic        eth_en;
   logic [7:0]  eth_data;
   logic [1:0]  grant;
   logic        frame_done;
   logic        underrun;
   logic        clr_status;

   eth_frame_scheduler #(.PAYLOAD_LEN(PL), .IFG_CYCLES(IFG)) dut (
      .clk(clk), .rst(rst), .ch_enable(ch_enable), .ch_ready(ch_ready),
      .ch_empty(ch_empty), .ch_dout(ch_dout), .ch_rd_en(ch_rd_en),
      .din_rdy(din_rdy), .eth_en(eth_en), .eth_data(eth_data), .grant(grant),
      .frame_done(frame_done), .underrun(underrun), .clr_status(clr_status)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Bench-side FWFT FIFOs; forceEmpty fakes an empty flag without losing data.
   logic [7:0] mem [4][2048];
   int         rdp [4];
   int         wrp [4];
   logic [7:0] fout [4];
   logic [3:0] qEmpty = 4'hF;
   logic [3:0] forceEmpty = 4'h0;
   logic [3:0] pendPop = 4'h0;

   assign ch_dout  = {fout[3], fout[2], fout[1], fout[0]};
   assign ch_empty = qEmpty | forceEmpty;

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 4; i++) begin
         if (pendPop[i] && rdp[i] != wrp[i]) rdp[i] = rdp[i] + 1;
         qEmpty[i] = (rdp[i] == wrp[i]);
         fout[i]   = mem[i][rdp[i]];
      end
   end

   logic [7:0] txq [$];
   int         doneCnt;
   int         popCnt [4];

   bit         mActive;
   bit         mDone;
   bit         mUnder;
   int         mPos;
   int         mGap;
   logic [1:0] mGrant;
   logic [1:0] mLast;
   logic [7:0] mSeq [4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame is PL+2 transfers, then IFG idle cycles, then arbitration.
   always @(posedge clk) begin
      logic [3:0] req;
      bit found;
      int idx;
      if (rst) begin
         mActive = 0; mDone = 0; mUnder = 0; mPos = 0; mGap = 0;
         mGrant = 2'd0; mLast = 2'd3;
         for (int i = 0; i < 4; i++) mSeq[i] = 8'd0;
      end else begin
         if (mActive && mPos >= 2 && din_rdy && ch_empty[mGrant]) mUnder = 1;
         else if (clr_status) mUnder = 0;
         mDone = 0;
         if (mActive) begin
            if (din_rdy) begin
               if (mPos == PL + 1) begin
                  mActive = 0; mGap = IFG; mDone = 1;
                  mSeq[mGrant] = mSeq[mGrant] + 8'd1;
                  mLast = mGrant;
               end else begin
                  mPos++;
               end
            end
         end else if (mGap > 0) begin
            mGap--;
         end else begin
            req = ch_ready & ch_enable;
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               idx = (int'(mLast) + k) % 4;
               if (!found && req[idx]) begin
                  mGrant = 2'(idx);
                  found = 1;
               end
            end
            if (found) begin
               mActive = 1; mPos = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] expData;
      logic [3:0] expRd;
      pendPop = ch_rd_en;
      if (!rst) begin
         expData = 8'h00;
         expRd   = 4'h0;
         if (mActive) begin
            if (mPos == 0) expData = {4'hA, 2'b00, mGrant};
            else if (mPos == 1) expData = mSeq[mGrant];
            else begin
               if (!ch_empty[mGrant]) expData = ch_dout[{mGrant, 3'b000} +: 8];
               if (din_rdy && !ch_empty[mGrant]) expRd[mGrant] = 1'b1;
            end
         end
         checkOutput("eth_en", 32'(eth_en), 32'(mActive));
         checkOutput("eth_data", 32'(eth_data), 32'(expData));
         checkOutput("ch_rd_en", 32'(ch_rd_en), 32'(expRd));
         checkOutput("grant", 32'(grant), 32'(mGrant));
         checkOutput("frame_done", 32'(frame_done), 32'(mDone));
         checkOutput("underrun", 32'(underrun), 32'(mUnder));
         if (eth_en && din_rdy) txq.push_back(eth_data);
         if (frame_done) doneCnt++;
         for (int i = 0; i < 4; i++) popCnt[i] += int'(ch_rd_en[i]);
      end
   end

   function automatic logic [31:0] getTx(input int i);
      return (i < txq.size()) ? 32'(txq[i]) : 32'h1FF;
   endfunction

   task automatic clearLog();
      txq.delete();
      doneCnt = 0;
      for (int i = 0; i < 4; i++) popCnt[i] = 0;
   endtask

   task automatic applyStimulus(input logic [3:0] rdyV, input logic dinV, input logic clrV);
      ch_ready   = rdyV;
      din_rdy    = dinV;
      clr_status = clrV;
      @(posedge clk);
      #1;
   endtask

   task automatic pushByte(input int ch, input logic [7:0] b);
      mem[ch][wrp[ch]] = b;
      wrp[ch] = wrp[ch] + 1;
   endtask

   task automatic resetDut();
      rst = 1'b1; ch_ready = 4'h0; din_rdy = 1'b1; clr_status = 1'b0; forceEmpty = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin rdp[i] = 0; wrp[i] = 0; end
      clearLog();
      @(negedge clk);
      checkOutput("rst_eth_en", 32'(eth_en), 32'h0);
      checkOutput("rst_eth_data", 32'(eth_data), 32'h0);
      checkOutput("rst_rd_en", 32'(ch_rd_en), 32'h0);
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_done_underrun", 32'({frame_done, underrun}), 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDone(input int target, input int budget);
      int n = 0;
      while (doneCnt < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("frame_done_wait", 32'(doneCnt >= target), 32'h1);
   endtask

   task automatic waitTx(input int target, input int budget);
      int n = 0;
      while (txq.size() < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("transfer_wait", 32'(txq.size() >= target), 32'h1);
   endtask

   logic [7:0] exp1 [6] = '{8'hA0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] exp2 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
   logic [7:0] exp4 [6] = '{8'hA1, 8'h00, 8'h55, 8'h00, 8'h66, 8'h77};

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; ch_enable = 4'hF; ch_ready = 4'h0; din_rdy = 1'b1; clr_status = 1'b0;
      for (int i = 0; i < 4; i++) begin rdp[i] = 0; wrp[i] = 0; end

      // Single ch0 frame.
      resetDut();
      pushByte(0, 8'h11); pushByte(0, 8'h22); pushByte(0, 8'h33); pushByte(0, 8'h44);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      waitDone(1, 40);
      repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("s1_len", 32'(txq.size()), 32'd6);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("s1_byte%0d", i), getTx(i), 32'(exp1[i]));
      checkOutput("s1_pops", 32'(popCnt[0]), 32'd4);
      checkOutput("s1_done", 32'(doneCnt), 32'd1);

      // Round robin across all channels, ch0 served twice.
      resetDut();
      for (int c = 0; c < 4; c++)
         for (int j = 0; j < 4; j++) pushByte(c, 8'(16 * c + j));
      for (int j = 0; j < 4; j++) pushByte(0, 8'(8'hE0 + j));
      ch_ready = 4'hF;
      waitDone(5, 200);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) checkOutput($sformatf("s2_hdr%0d", k), getTx(6 * k), 32'(exp2[k]));
      checkOutput("s2_ch0_seq", getTx(25), 32'h01);

      // din_rdy toggling must not change bytes or pops.
      resetDut();
      pushByte(0, 8'h11); pushByte(0, 8'h22); pushByte(0, 8'h33); pushByte(0, 8'h44);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      for (int n = 0; n < 60 && doneCnt < 1; n++) applyStimulus(4'b0000, n[0] == 1'b0, 1'b0);
      repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("s3_len", 32'(txq.size()), 32'd6);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("s3_byte%0d", i), getTx(i), 32'(exp1[i]));
      checkOutput("s3_pops", 32'(popCnt[0]), 32'd4);

      // Underrun on the second ch1 payload byte.
      resetDut();
      pushByte(1, 8'h55); pushByte(1, 8'h66); pushByte(1, 8'h77); pushByte(1, 8'h88);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      waitTx(3, 40);
      forceEmpty = 4'b0010;
      applyStimulus(4'b0000, 1'b1, 1'b0);
      forceEmpty = 4'b0000;
      waitDone(1, 40);
      repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("s4_byte%0d", i), getTx(i), 32'(exp4[i]));
      checkOutput("s4_pops", 32'(popCnt[1]), 32'd3);
      checkOutput("s4_underrun_held", 32'(underrun), 32'h1);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("s4_underrun_clr", 32'(underrun), 32'h0);

      // 257 ch2 frames: sequence number wraps on the last one.
      resetDut();
      for (int f = 0; f < 257; f++)
         for (int j = 0; j < 4; j++) pushByte(2, 8'(4 * f + j));
      ch_ready = 4'b0100;
      waitDone(257, 257 * 12);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("s5_hdr_257", getTx(256 * 6), 32'hA2);
      checkOutput("s5_seq_256", getTx(255 * 6 + 1), 32'hFF);
      checkOutput("s5_seq_257", getTx(256 * 6 + 1), 32'h00);

      // Reset in the middle of a payload.
      resetDut();
      pushByte(0, 8'h11); pushByte(0, 8'h22); pushByte(0, 8'h33); pushByte(0, 8'h44);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      waitTx(3, 40);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("s6_rd_en_in_rst", 32'(ch_rd_en), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("s6_eth_en", 32'(eth_en), 32'h0);
      checkOutput("s6_rd_en", 32'(ch_rd_en), 32'h0);
      checkOutput("s6_grant", 32'(grant), 32'h0);
      @(posedge clk);
      #1;
      clearLog();
      pushByte(0, 8'h55); pushByte(0, 8'h66); pushByte(0, 8'h77); pushByte(0, 8'h88);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      waitDone(1, 40);
      repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("s6_hdr0", getTx(0), 32'hA0);
      checkOutput("s6_hdr1", getTx(1), 32'h00);
      checkOutput("s6_first_payload", getTx(2), 32'h22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_frame_scheduler.md
ETH_FRAME_SCHEDULER -- requirements
Module: eth_frame_scheduler

Interface
REQ-001 Parameter PAYLOAD_LEN, default 1024: payload bytes per frame, legal range 1..4096.
REQ-002 Parameter IFG_CYCLES, default 16: idle cycles between frames, legal range 1..255.
REQ-003 clk  input  1  clk_125m domain; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ch_enable  input  4  per-channel arbitration enable.
REQ-006 ch_ready  input  4  per-channel FIFO holds at least one frame (rd_full flag).
REQ-007 ch_empty  input  4  per-channel FIFO empty.
REQ-008 ch_dout  input  32  four 8-bit FWFT FIFO outputs; channel i on bits [8i+7:8i].
REQ-009 ch_rd_en  output  4  one-hot FIFO pop strobe.
REQ-010 din_rdy  input  1  transmitter accepts eth_data this cycle.
REQ-011 eth_en  output  1  frame active toward transmitter.
REQ-012 eth_data  output  8  byte to transmitter.
REQ-013 grant  output  2  channel currently or last served.
REQ-014 frame_done  output  1  one-cycle pulse at frame end.
REQ-015 underrun  output  1  sticky: payload byte requested while granted FIFO empty.
REQ-016 clr_status  input  1  clears underrun.

Function
REQ-017 States: IDLE, HDR0, HDR1, PAYLOAD, GAP; the scheduler SHALL implement exactly these.
REQ-018 Request vector SHALL be ch_ready & ch_enable, sampled only in IDLE.
REQ-019 IDLE with nonzero request SHALL register grant by round-robin, searching from (last_grant+1) mod 4 upward, and SHALL go to HDR0 next cycle.
REQ-020 eth_en SHALL be registered, high in HDR0, HDR1 and PAYLOAD, low in IDLE and GAP.
REQ-021 A byte transfers only on cycles with eth_en=1 and din_rdy=1; state SHALL hold while din_rdy=0.
REQ-022 HDR0 eth_data SHALL be {4'hA, 2'b00, grant}; advance to HDR1 on transfer.
REQ-023 HDR1 eth_data SHALL be seq[grant], the channel's 8-bit frame counter; advance to PAYLOAD on transfer.
REQ-024 PAYLOAD eth_data SHALL be combinationally ch_dout[grant]; ch_rd_en[grant] = din_rdy & ~ch_empty[grant]; all other ch_rd_en bits 0.
REQ-025 PAYLOAD byte with din_rdy=1 and ch_empty[grant]=1: eth_data=8'h00, no pop, byte still counted, underrun set.
REQ-026 Byte counter SHALL count PAYLOAD_LEN transfers; the last transfer SHALL move to GAP, pulse frame_done next cycle, increment seq[grant] (255 wraps to 0), and update last_grant to grant.
REQ-027 GAP SHALL last exactly IFG_CYCLES cycles then enter IDLE.
REQ-028 Changes of ch_ready/ch_enable/ch_empty during HDR0..GAP SHALL not alter grant or abort the frame.
REQ-029 ch_rd_en SHALL be 0 outside PAYLOAD.
REQ-030 clr_status SHALL clear underrun; underrun set in the same cycle SHALL win.
REQ-031 Outside HDR0, HDR1 and PAYLOAD, eth_data SHALL be 8'h00.

Reset
REQ-032 rst SHALL force IDLE, eth_en=0, eth_data=0, ch_rd_en=0, frame_done=0, underrun=0, grant=0, last_grant=3, all seq=0, byte and gap counters 0.
REQ-033 rst mid-frame SHALL abort within one cycle with no further ch_rd_en; seq is not incremented for the aborted frame.

Verification (PAYLOAD_LEN=4, IFG_CYCLES=2)
REQ-034 ch_ready=4'b0001, din_rdy=1, ch0 data 11,22,33,44 -> eth_data A0,00,11,22,33,44; 4 ch_rd_en[0] pulses; frame_done once; eth_en low 2 cycles.
REQ-035 ch_ready=4'b1111 held -> grant sequence 0,1,2,3,0; second ch0 header byte HDR1=01.
REQ-036 din_rdy toggled 1,0,1,0 through frame -> identical byte sequence, no duplicated or lost pops, 6 transfers total.
REQ-037 ch1 granted, ch_empty[1]=1 for 2nd payload byte -> that byte 00, no pop, underrun=1 until clr_status.
REQ-038 257 frames on ch2 -> HDR1 of frame 257 = 00 (wrap).
REQ-039 rst asserted during PAYLOAD -> next cycle eth_en=0, ch_rd_en=0, grant=0; following frame HDR1=00.
